// File: rtl/dataload_pkg.sv
// ============================================================================
// Module      : dataload_pkg
// Description : Shared types and defaults for the dataload_mc frame loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dataload_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic {
    LOAD_WEIGHT = 1'b0,
    LOAD_INPUT  = 1'b1
  } load_type_e;

  typedef enum logic {
    BUF_FILL = 1'b0,
    BUF_FULL = 1'b1
  } buf_state_e;

endpackage : dataload_pkg

`default_nettype wire

// File: rtl/dataload_mc_if.sv
// ============================================================================
// Module      : dataload_mc_if
// Description : Load-port and frame-output bundle for dataload_mc.
//               Fill-count signals exist only with DATALOAD_FILL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dataload_mc_if #(
  parameter int DATA_W       = dataload_pkg::DEFAULT_DATA_W,
  parameter int INPUT_WORDS  = 8,
  parameter int WEIGHT_WORDS = 1
);
  import dataload_pkg::*;

  logic [DATA_W-1:0]              data_i;
  logic                           load_en_i;
  load_type_e                     load_type;
  logic                           load_ready_o;
  logic                           flush_i;
  logic                           weight_consume_i;
  logic                           input_consume_i;
  logic [WEIGHT_WORDS*DATA_W-1:0] weight_o;
  logic                           weight_valid;
  logic [INPUT_WORDS*DATA_W-1:0]  first_level_input_data;
  logic                           input_valid;
`ifdef DATALOAD_FILL_CNT_EN
  logic [$clog2(WEIGHT_WORDS+1)-1:0] weight_fill_o;
  logic [$clog2(INPUT_WORDS+1)-1:0]  input_fill_o;
`endif

  modport master (
    output data_i, load_en_i, load_type, flush_i, weight_consume_i, input_consume_i,
`ifdef DATALOAD_FILL_CNT_EN
    input  weight_fill_o, input_fill_o,
`endif
    input  load_ready_o, weight_o, weight_valid, first_level_input_data, input_valid
  );

  modport slave (
    input  data_i, load_en_i, load_type, flush_i, weight_consume_i, input_consume_i,
`ifdef DATALOAD_FILL_CNT_EN
    output weight_fill_o, input_fill_o,
`endif
    output load_ready_o, weight_o, weight_valid, first_level_input_data, input_valid
  );

endinterface : dataload_mc_if

`default_nettype wire

// File: rtl/frame_buffer.sv
// ============================================================================
// Module      : frame_buffer
// Description : Shift-register frame assembler with FILL/FULL states,
//               consume and flush. Optional fill port (DATALOAD_FILL_CNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_buffer
  import dataload_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int FW     = DEPTH * DATA_W
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              flush,
  input  wire logic              wr_en,
  input  wire logic [DATA_W-1:0] wr_data,
  input  wire logic              consume,
`ifdef DATALOAD_FILL_CNT_EN
  output logic [CNT_W-1:0]       fill,
`endif
  output logic [FW-1:0]          frame,
  output logic                   valid
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  buf_state_e        state, state_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [FW-1:0]     frame_q, shifted;
  logic              shift;

  // New words enter the top lane; the oldest word ends up in the bottom lane.
  generate
    if (DEPTH == 1) begin : g_single
      assign shifted = wr_data;
    end else begin : g_multi
      assign shifted = {wr_data, frame_q[FW-1:DATA_W]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state   <= BUF_FILL;
      count   <= '0;
      frame_q <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (shift) frame_q <= shifted;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    shift     = 1'b0;
    case (state)
      BUF_FILL: begin
        if (wr_en) begin
          shift = 1'b1;
          if (count == LAST_CNT) begin
            state_nxt = BUF_FULL;
            count_nxt = FULL_CNT;
          end else begin
            count_nxt = count + CNT_W'(1);
          end
        end
      end
      BUF_FULL: begin
        // A write alongside consume is the first word of the next frame.
        if (consume) begin
          if (wr_en) begin
            shift = 1'b1;
            if (DEPTH == 1) begin
              count_nxt = FULL_CNT;
            end else begin
              state_nxt = BUF_FILL;
              count_nxt = CNT_W'(1);
            end
          end else begin
            state_nxt = BUF_FILL;
            count_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = BUF_FILL;
        count_nxt = '0;
      end
    endcase
  end

  assign frame = frame_q;
  assign valid = (state == BUF_FULL);
`ifdef DATALOAD_FILL_CNT_EN
  assign fill  = count;
`endif

endmodule : frame_buffer

`default_nettype wire

// File: rtl/dataload_mc.sv
// ============================================================================
// Module      : dataload_mc
// Description : Steers a valid/ready word stream into weight and input frame
//               buffers. Fill-count ports exist with DATALOAD_FILL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dataload_mc
  import dataload_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int INPUT_WORDS  = 8,
  parameter int WEIGHT_WORDS = 1
) (
  input wire logic     clk,
  input wire logic     rst,
  dataload_mc_if.slave bus
);

  logic sel_input;
  logic ready;
  logic accept;
  logic weight_full;
  logic input_full;

  assign sel_input = (bus.load_type == LOAD_INPUT);

  always_comb begin
    ready = 1'b0;
    if (sel_input) ready = !input_full  || bus.input_consume_i;
    else           ready = !weight_full || bus.weight_consume_i;
  end

  assign accept           = bus.load_en_i && ready;
  assign bus.load_ready_o = ready;
  assign bus.weight_valid = weight_full;
  assign bus.input_valid  = input_full;

  frame_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (WEIGHT_WORDS)
  ) u_weight_buf (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.flush_i),
    .wr_en   (accept && !sel_input),
    .wr_data (bus.data_i),
    .consume (bus.weight_consume_i),
`ifdef DATALOAD_FILL_CNT_EN
    .fill    (bus.weight_fill_o),
`endif
    .frame   (bus.weight_o),
    .valid   (weight_full)
  );

  frame_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (INPUT_WORDS)
  ) u_input_buf (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.flush_i),
    .wr_en   (accept && sel_input),
    .wr_data (bus.data_i),
    .consume (bus.input_consume_i),
`ifdef DATALOAD_FILL_CNT_EN
    .fill    (bus.input_fill_o),
`endif
    .frame   (bus.first_level_input_data),
    .valid   (input_full)
  );

endmodule : dataload_mc

`default_nettype wire

// File: tb/tb_dataload_mc.sv
// ============================================================================
// Module      : tb_dataload_mc
// Description : Directed self-checking bench for dataload_mc (default params).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dataload_mc;
  import dataload_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dataload_mc_if #(.DATA_W(32), .INPUT_WORDS(8), .WEIGHT_WORDS(1)) bus ();

  dataload_mc #(.DATA_W(32), .INPUT_WORDS(8), .WEIGHT_WORDS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.load_en_i        = 1'b0;
    bus.weight_consume_i = 1'b0;
    bus.input_consume_i  = 1'b0;
    bus.flush_i          = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input load_type_e t, input logic [31:0] d, input logic wc, input logic ic);
    bus.load_en_i        = 1'b1;
    bus.load_type        = t;
    bus.data_i           = d;
    bus.weight_consume_i = wc;
    bus.input_consume_i  = ic;
    tick();
    idle();
  endtask

  localparam logic [255:0] FRAME_A = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
  localparam logic [255:0] FRAME_B = 256'h00000018_00000017_00000016_00000015_00000014_00000013_00000012_00000011;
  localparam logic [255:0] FRAME_C = 256'h00000038_00000037_00000036_00000035_00000034_00000033_00000032_00000031;

  initial begin
    logic [255:0] frame;
    idle();
    bus.load_type = LOAD_INPUT;
    bus.data_i    = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_wvalid", bus.weight_valid, 0);
    check("rst_ivalid", bus.input_valid, 0);
    check("rst_wdata", bus.weight_o, 0);
    check("rst_idata", bus.first_level_input_data, 0);
    check("rst_ready", bus.load_ready_o, 1);
`ifdef DATALOAD_FILL_CNT_EN
    check("rst_ifill", bus.input_fill_o, 0);
    check("rst_wfill", bus.weight_fill_o, 0);
`endif

    // Full input frame 1..8
    for (int i = 1; i <= 7; i++) send(LOAD_INPUT, 32'(i), 1'b0, 1'b0);
    check("in7_valid", bus.input_valid, 0);
`ifdef DATALOAD_FILL_CNT_EN
    check("in7_fill", bus.input_fill_o, 7);
`endif
    send(LOAD_INPUT, 32'h8, 1'b0, 1'b0);
    check("in8_valid", bus.input_valid, 1);
    frame = bus.first_level_input_data;
    check("in8_lo", frame[31:0], 32'h1);
    check("in8_hi", frame[255:224], 32'h8);
    check("in8_frame", frame, FRAME_A);
    bus.load_type = LOAD_INPUT;
    #1;
    check("in_full_ready", bus.load_ready_o, 0);
    bus.input_consume_i = 1'b1;
    tick();
    idle();
    check("in_consumed", bus.input_valid, 0);

    // Depth-1 weight frame, backpressure, consume+write
    send(LOAD_WEIGHT, 32'hA5A5A5A5, 1'b0, 1'b0);
    check("w_valid", bus.weight_valid, 1);
    check("w_data", bus.weight_o, 32'hA5A5A5A5);
    bus.load_en_i = 1'b1;
    bus.load_type = LOAD_WEIGHT;
    bus.data_i    = 32'h11111111;
    #1;
    check("w_full_ready", bus.load_ready_o, 0);
    tick();
    idle();
    check("w_frozen", bus.weight_o, 32'hA5A5A5A5);
    send(LOAD_WEIGHT, 32'h5A5A5A5A, 1'b1, 1'b0);
    check("w_cw_valid", bus.weight_valid, 1);
    check("w_cw_data", bus.weight_o, 32'h5A5A5A5A);
    bus.weight_consume_i = 1'b1;
    tick();
    idle();
    check("w_consumed", bus.weight_valid, 0);

    // Interleaved input/weight
    for (int i = 0; i < 3; i++) send(LOAD_INPUT, 32'h11 + 32'(i), 1'b0, 1'b0);
    send(LOAD_WEIGHT, 32'hBB, 1'b0, 1'b0);
    check("il_wvalid", bus.weight_valid, 1);
    check("il_ivalid_mid", bus.input_valid, 0);
    for (int i = 3; i < 8; i++) send(LOAD_INPUT, 32'h11 + 32'(i), 1'b0, 1'b0);
    check("il_ivalid", bus.input_valid, 1);
    check("il_frame", bus.first_level_input_data, FRAME_B);
    check("il_wdata", bus.weight_o, 32'hBB);
    bus.weight_consume_i = 1'b1;
    bus.input_consume_i  = 1'b1;
    tick();
    idle();
    check("il_consumed", {bus.weight_valid, bus.input_valid}, 0);

    // Flush with partial input and full weight, word offered in flush cycle
    for (int i = 0; i < 5; i++) send(LOAD_INPUT, 32'h21 + 32'(i), 1'b0, 1'b0);
    send(LOAD_WEIGHT, 32'hCC, 1'b0, 1'b0);
    bus.flush_i   = 1'b1;
    bus.load_en_i = 1'b1;
    bus.load_type = LOAD_INPUT;
    bus.data_i    = 32'h99;
    tick();
    idle();
    check("fl_ivalid", bus.input_valid, 0);
    check("fl_wvalid", bus.weight_valid, 0);
    check("fl_idata", bus.first_level_input_data, 0);
    check("fl_wdata", bus.weight_o, 0);
`ifdef DATALOAD_FILL_CNT_EN
    check("fl_ifill", bus.input_fill_o, 0);
`endif
    for (int i = 0; i < 7; i++) send(LOAD_INPUT, 32'h31 + 32'(i), 1'b0, 1'b0);
    check("fl_7_valid", bus.input_valid, 0);
    send(LOAD_INPUT, 32'h38, 1'b0, 1'b0);
    check("fl_8_valid", bus.input_valid, 1);
    check("fl_frame", bus.first_level_input_data, FRAME_C);

    // Input full, weight path still open
    bus.load_type = LOAD_WEIGHT;
    #1;
    check("ind_ready", bus.load_ready_o, 1);
    send(LOAD_WEIGHT, 32'hDD, 1'b0, 1'b0);
    check("ind_wvalid", bus.weight_valid, 1);
    check("ind_wdata", bus.weight_o, 32'hDD);
    check("ind_ivalid", bus.input_valid, 1);
    check("ind_iframe", bus.first_level_input_data, FRAME_C);

    // Consume+write on input starts next frame, then reset mid-frame
    send(LOAD_INPUT, 32'h41, 1'b0, 1'b1);
    check("cw_ivalid", bus.input_valid, 0);
    send(LOAD_INPUT, 32'h42, 1'b0, 1'b0);
`ifdef DATALOAD_FILL_CNT_EN
    check("cw_ifill", bus.input_fill_o, 2);
`endif
    frame = bus.first_level_input_data;
    check("cw_top", frame[255:192], 64'h00000042_00000041);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.load_type = LOAD_INPUT;
    #1;
    check("mr_ivalid", bus.input_valid, 0);
    check("mr_wvalid", bus.weight_valid, 0);
    check("mr_idata", bus.first_level_input_data, 0);
    check("mr_wdata", bus.weight_o, 0);
    check("mr_ready", bus.load_ready_o, 1);
`ifdef DATALOAD_FILL_CNT_EN
    check("mr_ifill", bus.input_fill_o, 0);
    check("mr_wfill", bus.weight_fill_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dataload_mc

`default_nettype wire
